// File: rtl/elastic_pipeline_reg.sv
// Elastic two-entry pipeline register (main + skid) with registered ready/valid,
// global stall, flush, and a saturating count of held-but-not-consumed cycles.
module elastic_pipeline_reg #(
    parameter int                    DATA_WIDTH      = 64,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE    = {DATA_WIDTH{1'b0}},
    parameter int                    STALL_CNT_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       BUSYWAIT,
    input  logic                       FLUSH,
    input  logic [DATA_WIDTH-1:0]      IN_DATA,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    output logic [DATA_WIDTH-1:0]      OUT_DATA,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [STALL_CNT_WIDTH-1:0] STALL_COUNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t                     state;
    logic [DATA_WIDTH-1:0]      main_q;
    logic [DATA_WIDTH-1:0]      skid_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;
    logic                       in_fire;
    logic                       out_fire;

    // Handshake outputs decode the state register only, so no input reaches them.
    assign IN_READY    = (state != SKID);
    assign OUT_VALID   = (state != EMPTY);
    assign OUT_DATA    = main_q;
    assign STALL_COUNT = stall_cnt;

    assign in_fire  = IN_VALID  & IN_READY  & ~BUSYWAIT & ~FLUSH;
    assign out_fire = OUT_VALID & OUT_READY & ~BUSYWAIT & ~FLUSH;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= EMPTY;
            main_q    <= BUBBLE_VALUE;
            skid_q    <= '0;
            stall_cnt <= '0;
        end else begin
            if ((state != EMPTY) && !out_fire && (stall_cnt != {STALL_CNT_WIDTH{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;

            // Flush wins over busywait; busywait alone suppresses both fires and thus holds.
            if (FLUSH) begin
                state  <= EMPTY;
                main_q <= BUBBLE_VALUE;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            main_q <= IN_DATA;
                            state  <= FULL;
                        end
                    end
                    FULL: begin
                        if (in_fire && out_fire) begin
                            main_q <= IN_DATA;
                        end else if (in_fire) begin
                            skid_q <= IN_DATA;
                            state  <= SKID;
                        end else if (out_fire) begin
                            main_q <= BUBBLE_VALUE;
                            state  <= EMPTY;
                        end
                    end
                    SKID: begin
                        if (out_fire) begin
                            main_q <= skid_q;
                            state  <= FULL;
                        end
                    end
                    default: begin
                        state  <= EMPTY;
                        main_q <= BUBBLE_VALUE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_elastic_pipeline_reg.sv
// Randomized + directed bench for elastic_pipeline_reg, checked against a
// queue-based model of a two-deep in-order buffer.
module tb_elastic_pipeline_reg;

    localparam int          DW  = 32;
    localparam int          CW  = 4;
    localparam logic [31:0] BUB = 32'h0000_0013;
    localparam int          SAT = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RESET, BUSYWAIT, FLUSH, IN_VALID, OUT_READY;
    logic [DW-1:0] IN_DATA;
    logic          IN_READY, OUT_VALID;
    logic [DW-1:0] OUT_DATA;
    logic [CW-1:0] STALL_COUNT;

    always #5 CLK = ~CLK;

    elastic_pipeline_reg #(
        .DATA_WIDTH     (DW),
        .BUBBLE_VALUE   (BUB),
        .STALL_CNT_WIDTH(CW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BUSYWAIT   (BUSYWAIT),
        .FLUSH      (FLUSH),
        .IN_DATA    (IN_DATA),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .STALL_COUNT(STALL_COUNT)
    );

    logic [31:0] q[$];
    int          mcnt   = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge: drive inputs, advance the model with pre-edge values, compare after the edge.
    task automatic cycle(input bit rst, input bit bsy, input bit fl, input bit iv,
                         input logic [31:0] d, input bit ordy);
        bit ifire, ofire;
        int sz;
        RESET     = rst;
        BUSYWAIT  = bsy;
        FLUSH     = fl;
        IN_VALID  = iv;
        IN_DATA   = d;
        OUT_READY = ordy;
        sz    = q.size();
        ifire = iv && (sz < 2) && !bsy && !fl;
        ofire = ordy && (sz > 0) && !bsy && !fl;
        @(posedge CLK);
        #1;
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            if (sz > 0 && !ofire && mcnt < SAT) mcnt++;
            if (fl) q.delete();
            else begin
                if (ofire) void'(q.pop_front());
                if (ifire) q.push_back(d);
            end
        end
        check("out_valid",   32'(OUT_VALID),   32'(q.size() > 0));
        check("in_ready",    32'(IN_READY),    32'(q.size() < 2));
        check("out_data",    OUT_DATA,         (q.size() > 0) ? q[0] : BUB);
        check("stall_count", 32'(STALL_COUNT), 32'(mcnt));
    endtask

    initial begin
        // Reset with a live input offered
        cycle(1, 0, 0, 1, 32'hA, 0);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_data",  OUT_DATA,       BUB);
        check("rst_in_ready",  32'(IN_READY),  32'd1);
        check("rst_stall",     32'(STALL_COUNT), 32'd0);

        // Streaming at full rate
        cycle(0, 0, 0, 1, 32'h10, 1); check("stream0", OUT_DATA, 32'h10);
        cycle(0, 0, 0, 1, 32'h20, 1); check("stream1", OUT_DATA, 32'h20);
        cycle(0, 0, 0, 1, 32'h30, 1); check("stream2", OUT_DATA, 32'h30);
        cycle(0, 0, 0, 0, 32'h0, 1);
        check("stream_stall", 32'(STALL_COUNT), 32'd0);

        // Skid fill, source holds 0x30 while not ready, then drain in order
        cycle(0, 0, 0, 1, 32'h10, 0);
        cycle(0, 0, 0, 1, 32'h20, 0);
        check("skid_in_ready", 32'(IN_READY), 32'd0);
        check("skid_head",     OUT_DATA,      32'h10);
        cycle(0, 0, 0, 1, 32'h30, 0);
        cycle(0, 0, 0, 1, 32'h30, 1); check("skid_drain1", OUT_DATA, 32'h20);
        cycle(0, 0, 0, 1, 32'h30, 1); check("skid_drain2", OUT_DATA, 32'h30);
        cycle(0, 0, 0, 0, 32'h0, 1);  check("skid_empty", 32'(OUT_VALID), 32'd0);

        // Busywait freezes a FULL register and refuses new input
        cycle(0, 0, 0, 1, 32'h10, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 1, 32'h60, 1);
            check("bsy_hold", OUT_DATA, 32'h10);
        end
        cycle(0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);

        // Flush from SKID under busywait, input not captured
        cycle(0, 0, 0, 1, 32'h10, 0);
        cycle(0, 0, 0, 1, 32'h20, 0);
        cycle(0, 1, 1, 1, 32'h77, 0);
        check("flush_valid", 32'(OUT_VALID), 32'd0);
        check("flush_data",  OUT_DATA,       BUB);
        check("flush_ready", 32'(IN_READY),  32'd1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        check("flush_nocap", 32'(OUT_VALID), 32'd0);

        // Stall counter saturation
        cycle(1, 0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 1, 32'h10, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 32'h0, 0);
        check("sat_value", 32'(STALL_COUNT), 32'(SAT));
        cycle(0, 0, 0, 0, 32'h0, 0);
        check("sat_hold",  32'(STALL_COUNT), 32'(SAT));

        // Reset while in SKID
        cycle(0, 0, 0, 1, 32'h55, 0);
        check("pre_rst_skid", 32'(IN_READY), 32'd0);
        cycle(1, 1, 1, 1, 32'h66, 1);
        check("rst_skid_valid", 32'(OUT_VALID),   32'd0);
        check("rst_skid_cnt",   32'(STALL_COUNT), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 31) == 0),
                  $urandom_range(0, 1) == 1,
                  $urandom,
                  $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
